branch_predictor: RTL

// - IF-stage predictor that consumes the EX-stage branch resolution (comparator branch_taken).
// - Holds a direct-mapped table of 2-bit saturating counters plus a BTB (tag, target).
// - Predicts taken/target for the fetch PC; trains from resolved conditional branches.
// - Flags mispredicts so the hazard unit can flush IF/ID.

---
 rtl/branch_predictor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped 2-bit saturating counters plus a tagged BTB.
// Define BP_GSHARE_EN to XOR a global history register into the counter index.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_pred_taken_i,
  input  logic [XLEN-1:0] upd_pred_target_i,
  output logic            mispredict_o
);

  localparam int ENTRIES = 2 ** IDX_BITS;
  localparam int TAG_LSB = IDX_BITS + 2;
  localparam int TAG_MSB = TAG_LSB + TAG_BITS;

  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];
  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [XLEN-1:0]     target_d [ENTRIES];

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [IDX_BITS-1:0] if_ctr_idx;
  logic [IDX_BITS-1:0] upd_ctr_idx;
  logic [TAG_BITS-1:0] if_tag;
  logic [TAG_BITS-1:0] upd_tag;

  logic                if_hit;
  logic                pred_taken;
  logic                upd_hit;
  logic [1:0]          upd_ctr;
  logic                unused_pc_bits;

  assign if_idx  = if_pc_i[IDX_BITS+1:2];
  assign upd_idx = upd_pc_i[IDX_BITS+1:2];
  assign if_tag  = if_pc_i[TAG_LSB +: TAG_BITS];
  assign upd_tag = upd_pc_i[TAG_LSB +: TAG_BITS];

  // Byte offset and bits above the tag never participate in indexing or tagging.
  assign unused_pc_bits = ^{if_pc_i[1:0], if_pc_i[XLEN-1:TAG_MSB],
                            upd_pc_i[1:0], upd_pc_i[XLEN-1:TAG_MSB]};

`ifdef BP_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q;
  logic [IDX_BITS-1:0] ghr_d;

  // Both lookup and update hash with the history held before this cycle's shift.
  assign if_ctr_idx  = if_idx ^ ghr_q;
  assign upd_ctr_idx = upd_idx ^ ghr_q;

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid_i) begin
      ghr_d = {ghr_q[IDX_BITS-2:0], upd_taken_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign if_ctr_idx  = if_idx;
  assign upd_ctr_idx = upd_idx;
`endif

  always_comb begin
    if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken    = if_hit && ctr_q[if_ctr_idx][1];
    pred_taken_o  = pred_taken;
    pred_target_o = pred_taken ? target_q[if_idx] : (if_pc_i + XLEN'(4));
  end

  assign mispredict_o = upd_valid_i &&
                        ((upd_taken_i != upd_pred_taken_i) ||
                         (upd_taken_i && upd_pred_taken_i &&
                          (upd_target_i != upd_pred_target_i)));

  // A tag miss reloads the counter to a weak state instead of stepping it,
  // so a new branch does not inherit the strength of an aliasing one.
  always_comb begin
    ctr_d    = ctr_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr  = ctr_q[upd_ctr_idx];
    if (upd_valid_i) begin
      if (!upd_hit) begin
        ctr_d[upd_ctr_idx] = upd_taken_i ? 2'b10 : 2'b01;
      end else if (upd_taken_i) begin
        if (upd_ctr != 2'b11) begin
          ctr_d[upd_ctr_idx] = upd_ctr + 2'b01;
        end
      end else if (upd_ctr != 2'b00) begin
        ctr_d[upd_ctr_idx] = upd_ctr - 2'b01;
      end
      if (upd_taken_i) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]    <= 2'b01;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      ctr_q    <= ctr_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

endmodule
